// File: rtl/axi_pkg.sv
// Shared AXI constants, bridge FSM states and elaboration-time helpers.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_ADDR,
    ST_W_DATA,
    ST_W_RESP,
    ST_R_ADDR,
    ST_R_DATA,
    ST_FINISH
  } state_e;

  // Ceiling log2, usable in parameter expressions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the write and read data phases; flags the final beat.
module axi_beat_counter #(
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_last_c
);

  logic [LEN_W-1:0] r_count;

  // Count handshaken beats; cleared when a new command is accepted
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + LEN_W'(1);
    end
  end

  assign o_last_c = (r_count == (i_len - LEN_W'(1)));

endmodule

// File: rtl/axi_burst_master.sv
// Single-command AXI4 INCR burst master with streaming data and error reporting.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned AXI_ID    = 0,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned STRB_W    = DATA_W / 8,
  parameter int unsigned LEN_W     = clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              axi_stall,
  output logic [ID_W-1:0]   axi_awid,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic [1:0]        axi_awburst,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [STRB_W-1:0] axi_wstrb,
  output logic              axi_wlast,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [ID_W-1:0]   axi_bid,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  output logic [ID_W-1:0]   axi_arid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [ID_W-1:0]   axi_rid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready
);

  localparam int unsigned SIZE  = clog2(STRB_W);
  localparam int unsigned BND_W = 15;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_awvalid;
  logic              r_arvalid;
  logic              r_bready;
  logic              r_done;
  logic              r_err;
  logic              r_stall;

  logic              w_cmd_hs;
  logic              w_illegal;
  logic [BND_W-1:0]  w_end;
  logic              w_in_wdata;
  logic              w_in_rdata;
  logic              w_whs;
  logic              w_rhs;
  logic              w_last;
  logic              w_bbad;
  logic              w_rbad;

  // Command legality: length range, beat alignment, 4 KB boundary
  assign w_end     = BND_W'(cmd_addr[11:0]) + (BND_W'(cmd_len) << SIZE);
  assign w_illegal = (cmd_len == '0) || (32'(cmd_len) > MAX_BURST) ||
                     ((cmd_addr & ADDR_W'(STRB_W - 1)) != '0) ||
                     (w_end > BND_W'(4096));

  // cmd_ready is held low during the done cycle so a new command lands after it
  assign cmd_ready  = (r_state == ST_IDLE) && !r_done;
  assign w_cmd_hs   = cmd_valid && cmd_ready;
  assign w_in_wdata = (r_state == ST_W_DATA);
  assign w_in_rdata = (r_state == ST_R_DATA);

  // Data-phase pass-through, gated so nothing leaks outside its phase
  assign axi_wvalid = w_in_wdata && wr_valid;
  assign wr_ready   = w_in_wdata && axi_wready;
  assign axi_wdata  = wr_data;
  assign axi_wstrb  = wr_strb;
  assign axi_wlast  = w_in_wdata && w_last;
  assign w_whs      = axi_wvalid && axi_wready;

  assign rd_valid   = w_in_rdata && axi_rvalid;
  assign axi_rready = w_in_rdata && rd_ready;
  assign rd_data    = axi_rdata;
  assign rd_last    = w_in_rdata && axi_rlast;
  assign w_rhs      = axi_rvalid && axi_rready;

  assign w_bbad = (axi_bresp != RESP_OKAY) || (axi_bid != ID_W'(AXI_ID));
  assign w_rbad = (axi_rresp != RESP_OKAY) || (axi_rid != ID_W'(AXI_ID)) ||
                  (axi_rlast != w_last);

  // Address channels are driven from the latched command
  assign axi_awid    = ID_W'(AXI_ID);
  assign axi_awaddr  = r_addr;
  assign axi_awlen   = 8'(r_len - LEN_W'(1));
  assign axi_awsize  = 3'(SIZE);
  assign axi_awburst = BURST_INCR;
  assign axi_awvalid = r_awvalid;
  assign axi_arid    = ID_W'(AXI_ID);
  assign axi_araddr  = r_addr;
  assign axi_arlen   = 8'(r_len - LEN_W'(1));
  assign axi_arsize  = 3'(SIZE);
  assign axi_arburst = BURST_INCR;
  assign axi_arvalid = r_arvalid;
  assign axi_bready  = r_bready;

  assign done      = r_done;
  assign err       = r_done && r_err;
  assign axi_stall = r_stall;

  axi_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cmd_hs),
    .i_inc    (w_whs || w_rhs),
    .i_len    (r_len),
    .o_last_c (w_last)
  );

  // Burst sequencing FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_awvalid <= 1'b0;
      r_arvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_stall <= 1'b0;
          end else if (w_cmd_hs) begin
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_stall <= 1'b1;
            r_err   <= w_illegal;
            if (w_illegal) begin
              r_state <= ST_FINISH;
            end else if (cmd_write) begin
              r_state   <= ST_W_ADDR;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= ST_R_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_W_ADDR: begin
          if (axi_awready) begin
            r_awvalid <= 1'b0;
            r_state   <= ST_W_DATA;
          end
        end
        ST_W_DATA: begin
          if (w_whs && w_last) begin
            r_bready <= 1'b1;
            r_state  <= ST_W_RESP;
          end
        end
        ST_W_RESP: begin
          if (axi_bvalid) begin
            r_bready <= 1'b0;
            r_err    <= r_err || w_bbad;
            r_state  <= ST_FINISH;
          end
        end
        ST_R_ADDR: begin
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_R_DATA;
          end
        end
        ST_R_DATA: begin
          if (w_rhs) begin
            if (w_rbad) r_err <= 1'b1;
            if (axi_rlast || w_last) r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: directed commands, behavioural AXI slave.
`timescale 1ns/1ps
module tb_axi_burst_master;
  import axi_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LEN_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              rd_valid, rd_ready, rd_last;
  logic [DATA_W-1:0] rd_data;
  logic              done, err, axi_stall;
  logic [ID_W-1:0]   axi_awid, axi_arid, axi_bid, axi_rid;
  logic [ADDR_W-1:0] axi_awaddr, axi_araddr;
  logic [7:0]        axi_awlen, axi_arlen;
  logic [2:0]        axi_awsize, axi_arsize;
  logic [1:0]        axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic              axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [DATA_W-1:0] axi_wdata, axi_rdata;
  logic [STRB_W-1:0] axi_wstrb;
  logic              axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic              axi_rlast, axi_rvalid, axi_rready;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err), .axi_stall(axi_stall),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } a_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [31:0] data; logic last; } r_t;
  typedef struct packed { logic err; logic chk_lat; logic [7:0] lat; } d_t;

  a_t exp_aw[$];
  a_t exp_ar[$];
  w_t exp_w[$];
  r_t exp_rd[$];
  d_t exp_done[$];
  logic [35:0] src_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_accept = 0, n_done = 0, n_abort = 0, n_wbeat = 0, n_valid = 0;

  // Slave / sink knobs, driven by the stimulus thread
  logic [1:0]  bresp_cfg = 2'b00;
  logic        r_gaps = 1'b0;
  logic        rdrop = 1'b0;
  int          err_beat = 0;
  int          early_last = 0;
  logic [31:0] rmem [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or done
  initial begin : monitor
    a_t ea; w_t ew; r_t er; d_t ed;
    logic aw_seen;
    aw_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_seen = 1'b0;
      end else begin
        if (axi_awvalid || axi_arvalid || axi_wvalid) n_valid++;
        check("axi_stall", 64'(axi_stall), 64'(n_accept != n_done + n_abort));
        if (axi_awvalid && axi_awready) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 64'(1), 64'(0));
          else begin
            ea = exp_aw.pop_front();
            check("aw_fields", 64'({axi_awaddr, axi_awlen, axi_awsize, axi_awburst}), 64'(ea));
            check("aw_id", 64'(axi_awid), 64'(0));
          end
          aw_seen = 1'b1;
        end
        if (axi_arvalid && axi_arready) begin
          if (exp_ar.size() == 0) check("ar_unexpected", 64'(1), 64'(0));
          else begin
            ea = exp_ar.pop_front();
            check("ar_fields", 64'({axi_araddr, axi_arlen, axi_arsize, axi_arburst}), 64'(ea));
            check("ar_id", 64'(axi_arid), 64'(0));
          end
        end
        if (axi_wvalid && axi_wready) begin
          check("w_after_aw", 64'(aw_seen), 64'(1));
          if (exp_w.size() == 0) check("w_unexpected", 64'(1), 64'(0));
          else begin
            ew = exp_w.pop_front();
            check("w_beat", 64'({axi_wdata, axi_wstrb, axi_wlast}), 64'(ew));
          end
          n_wbeat++;
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
          else begin
            er = exp_rd.pop_front();
            check("rd_beat", 64'({rd_data, rd_last}), 64'(er));
          end
        end
        if (done) begin
          check("cmd_ready_in_done", 64'(cmd_ready), 64'(0));
          if (exp_done.size() == 0) check("done_unexpected", 64'(1), 64'(0));
          else begin
            ed = exp_done.pop_front();
            check("done_err", 64'(err), 64'(ed.err));
            if (ed.chk_lat) check("done_latency", 64'(cyc - acc_cyc), 64'(ed.lat));
          end
          n_done++;
          aw_seen = 1'b0;
        end
      end
    end
  end

  // Write-data source: presents queued beats, pops on handshake
  initial begin : source
    logic hs;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      wr_valid = (src_q.size() > 0);
      if (src_q.size() > 0) {wr_data, wr_strb} = src_q[0];
    end
  end

  // Write-response slave
  initial begin : wslave
    logic hs_wl, hs_b, rs;
    axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = '0;
    forever begin
      @(negedge clk);
      hs_wl = axi_wvalid && axi_wready && axi_wlast;
      hs_b  = axi_bvalid && axi_bready;
      rs    = rst;
      @(posedge clk); #1;
      if (rs) axi_bvalid = 1'b0;
      else begin
        if (hs_b) axi_bvalid = 1'b0;
        if (hs_wl) begin axi_bvalid = 1'b1; axi_bresp = bresp_cfg; axi_bid = '0; end
      end
    end
  end

  // Read-data slave with optional gaps, error beat and early rlast
  initial begin : rslave
    logic hs_ar, hs_r, rs, on;
    int total, idx;
    on = 1'b0; total = 0; idx = 0;
    axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0; axi_rid = '0;
    forever begin
      @(negedge clk);
      hs_ar = axi_arvalid && axi_arready;
      hs_r  = axi_rvalid && axi_rready;
      rs    = rst;
      if (hs_ar) total = int'(axi_arlen) + 1;
      @(posedge clk); #1;
      if (rs) begin
        on = 1'b0; axi_rvalid = 1'b0;
      end else begin
        if (hs_r) begin idx++; if (axi_rlast) on = 1'b0; end
        if (hs_ar) begin on = 1'b1; idx = 0; end
        if (!on) axi_rvalid = 1'b0;
        else if (!axi_rvalid || hs_r) axi_rvalid = r_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        axi_rdata = (idx < 16) ? rmem[idx] : 32'h0;
        axi_rlast = (idx == total - 1) || (idx == early_last - 1);
        axi_rresp = (idx == err_beat - 1) ? RESP_DECERR : RESP_OKAY;
        axi_rid   = '0;
      end
    end
  end

  // Read sink: optionally drops rd_ready every third cycle
  initial begin : sink
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rd_ready = rdrop ? ((cyc % 3) != 0) : 1'b1;
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [4:0] len);
    int t;
    logic ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    t = 0; ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else if (++t > 200) begin check("cmd_accept_timeout", 64'(0), 64'(1)); break; end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (ok) n_accept++;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (n_done + n_abort < n_accept) begin
      @(negedge clk);
      if (++t > 1000) begin check("done_timeout", 64'(0), 64'(1)); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nv, base, t;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    axi_awready = 1'b1; axi_arready = 1'b1; axi_wready = 1'b1;
    for (int i = 0; i < 16; i++) rmem[i] = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_valids", 64'({axi_awvalid, axi_arvalid, axi_wvalid, rd_valid, wr_ready}), 64'(0));
    check("rst_status", 64'({done, err, axi_stall, axi_bready, axi_rready}), 64'(0));
    check("rst_addr_len", 64'({axi_awaddr, axi_awlen}), 64'({32'h0, 8'hFF}));
    @(posedge clk); #1;
    rst = 1'b0;

    // Write len 4 at 0x100, data 1..4
    exp_aw.push_back({32'h100, 8'd3, 3'd2, 2'b01});
    for (int i = 1; i <= 4; i++) begin
      src_q.push_back({32'(i), 4'hF});
      exp_w.push_back({32'(i), 4'hF, (i == 4)});
    end
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    issue(1'b1, 32'h100, 5'd4);
    wait_done();

    // Read len 8 with slave gaps and sink backpressure
    for (int i = 0; i < 8; i++) begin
      rmem[i] = 32'hA0 + 32'(i);
      exp_rd.push_back({32'hA0 + 32'(i), (i == 7)});
    end
    r_gaps = 1'b1; rdrop = 1'b1;
    exp_ar.push_back({32'h200, 8'd7, 3'd2, 2'b01});
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    issue(1'b0, 32'h200, 5'd8);
    wait_done();
    r_gaps = 1'b0; rdrop = 1'b0;
    check("rd_queue_drained", 64'(exp_rd.size()), 64'(0));

    // Write with SLVERR response, AW held off for three cycles
    bresp_cfg = RESP_SLVERR; axi_awready = 1'b0;
    exp_aw.push_back({32'h40, 8'd1, 3'd2, 2'b01});
    src_q.push_back({32'h11, 4'h3}); exp_w.push_back({32'h11, 4'h3, 1'b0});
    src_q.push_back({32'h22, 4'hC}); exp_w.push_back({32'h22, 4'hC, 1'b1});
    exp_done.push_back({1'b1, 1'b0, 8'd0});
    issue(1'b1, 32'h40, 5'd2);
    repeat (3) begin
      @(negedge clk);
      check("aw_hold", 64'({axi_awvalid, axi_awaddr, axi_awlen}), 64'({1'b1, 32'h40, 8'd1}));
    end
    @(posedge clk); #1;
    axi_awready = 1'b1;
    wait_done();
    bresp_cfg = RESP_OKAY;

    // Read len 4 with DECERR on beat 2
    err_beat = 2;
    for (int i = 0; i < 4; i++) begin
      rmem[i] = 32'hB0 + 32'(i);
      exp_rd.push_back({32'hB0 + 32'(i), (i == 3)});
    end
    exp_ar.push_back({32'h300, 8'd3, 3'd2, 2'b01});
    exp_done.push_back({1'b1, 1'b0, 8'd0});
    issue(1'b0, 32'h300, 5'd4);
    wait_done();
    err_beat = 0;

    // Legal burst ending exactly on the 4 KB boundary
    for (int i = 0; i < 4; i++) begin
      rmem[i] = 32'hC0 + 32'(i);
      exp_rd.push_back({32'hC0 + 32'(i), (i == 3)});
    end
    exp_ar.push_back({32'hFF0, 8'd3, 3'd2, 2'b01});
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    issue(1'b0, 32'hFF0, 5'd4);
    wait_done();

    // Illegal commands: len 0, len MAX+1, 4 KB crossing, misaligned
    nv = n_valid; exp_done.push_back({1'b1, 1'b1, 8'd2}); issue(1'b1, 32'h0, 5'd0);   wait_done();
    check("ill_len0_no_axi", 64'(n_valid), 64'(nv));
    nv = n_valid; exp_done.push_back({1'b1, 1'b1, 8'd2}); issue(1'b0, 32'h0, 5'd17);  wait_done();
    check("ill_len17_no_axi", 64'(n_valid), 64'(nv));
    nv = n_valid; exp_done.push_back({1'b1, 1'b1, 8'd2}); issue(1'b0, 32'hFF8, 5'd4); wait_done();
    check("ill_4k_no_axi", 64'(n_valid), 64'(nv));
    nv = n_valid; exp_done.push_back({1'b1, 1'b1, 8'd2}); issue(1'b1, 32'h102, 5'd1); wait_done();
    check("ill_align_no_axi", 64'(n_valid), 64'(nv));

    // Read len 4 with premature rlast on beat 3
    early_last = 3;
    for (int i = 0; i < 4; i++) rmem[i] = 32'hD0 + 32'(i);
    for (int i = 0; i < 3; i++) exp_rd.push_back({32'hD0 + 32'(i), (i == 2)});
    exp_ar.push_back({32'h400, 8'd3, 3'd2, 2'b01});
    exp_done.push_back({1'b1, 1'b0, 8'd0});
    issue(1'b0, 32'h400, 5'd4);
    wait_done();
    early_last = 0;
    check("early_rlast_drained", 64'(exp_rd.size()), 64'(0));

    // Reset in the middle of a write after two beats
    base = n_wbeat;
    exp_aw.push_back({32'h500, 8'd3, 3'd2, 2'b01});
    src_q.push_back({32'h51, 4'hF}); exp_w.push_back({32'h51, 4'hF, 1'b0});
    src_q.push_back({32'h52, 4'hF}); exp_w.push_back({32'h52, 4'hF, 1'b0});
    issue(1'b1, 32'h500, 5'd4);
    t = 0;
    while (n_wbeat < base + 2) begin
      @(negedge clk);
      if (++t > 200) begin check("mid_write_timeout", 64'(0), 64'(1)); break; end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valids", 64'({axi_awvalid, axi_arvalid, axi_wvalid, axi_bready, axi_rready, rd_valid}), 64'(0));
    check("midrst_status", 64'({done, err, axi_stall, wr_ready}), 64'(0));
    check("midrst_idle", 64'(cmd_ready), 64'(1));
    n_abort++;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fresh read after reset
    rmem[0] = 32'hE0; rmem[1] = 32'hE1;
    exp_rd.push_back({32'hE0, 1'b0});
    exp_rd.push_back({32'hE1, 1'b1});
    exp_ar.push_back({32'h600, 8'd1, 3'd2, 2'b01});
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    issue(1'b0, 32'h600, 5'd2);
    wait_done();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("end_aw_q", 64'(exp_aw.size()), 64'(0));
    check("end_ar_q", 64'(exp_ar.size()), 64'(0));
    check("end_w_q", 64'(exp_w.size()), 64'(0));
    check("end_rd_q", 64'(exp_rd.size()), 64'(0));
    check("end_done_q", 64'(exp_done.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
